// File: rtl/simmem_pkg.sv
// Shared widths and slot record for the simulated-memory release scheduler.
// Sequence tags are one bit wider than the slot index so same-ID tags never alias.
package simmem_pkg;

  localparam int unsigned IDWidth      = 8;
  localparam int unsigned NumSlots     = 16;
  localparam int unsigned DelayWidth   = 8;
  localparam int unsigned SeqWidth     = $clog2(NumSlots) + 1;
  localparam int unsigned NumIds       = 2 ** IDWidth;
  localparam int unsigned SlotIdxWidth = $clog2(NumSlots);

  typedef struct packed {
    logic                  valid;
    logic [IDWidth-1:0]    id;
    logic [SeqWidth-1:0]   seq;
    logic [DelayWidth-1:0] cnt;
  } release_slot_t;

endpackage

// File: rtl/simmem_free_slot_finder.sv
// Priority encoder over free slots: lowest free index plus an any-free flag.
// Scanning from the top down lets the lowest free index win.
module simmem_free_slot_finder
  import simmem_pkg::*;
(
  input  logic [NumSlots-1:0]     valid,
  output logic [SlotIdxWidth-1:0] idx,
  output logic                    any_free
);

  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        idx      = SlotIdxWidth'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simmem_release_scheduler.sv
// Per-ID release scheduler: delayed slots, released strictly in same-ID order.
// The head of an ID is the valid slot whose tag equals that ID's dequeue tag.
module simmem_release_scheduler
  import simmem_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [IDWidth-1:0]    req_id_i,
  input  logic [DelayWidth-1:0] req_delay_i,
  output logic [NumIds-1:0]     release_en_o,
  input  logic                  rsp_valid_i,
  input  logic                  rsp_ready_i,
  input  logic [IDWidth-1:0]    rsp_id_i
);

  release_slot_t slots [NumSlots];

  logic [SeqWidth-1:0] enq_seq [NumIds];
  logic [SeqWidth-1:0] deq_seq [NumIds];

  logic [NumSlots-1:0]     slot_valid;
  logic [NumSlots-1:0]     retire_hit;
  logic [SlotIdxWidth-1:0] free_idx;
  logic                    any_free;
  logic                    accept;
  logic                    retire;
  logic [SeqWidth-1:0]     rsp_head_seq;
  logic [SeqWidth-1:0]     req_seq;

  for (genvar s = 0; s < NumSlots; s++) begin : g_valid
    assign slot_valid[s] = slots[s].valid;
  end

  simmem_free_slot_finder u_finder (
    .valid    (slot_valid),
    .idx      (free_idx),
    .any_free (any_free)
  );

  assign req_ready_o = any_free;
  assign accept      = req_valid_i && any_free;
  assign req_seq     = enq_seq[req_id_i];

  // One-hot head match per ID, qualified by expiry.
  for (genvar x = 0; x < NumIds; x++) begin : g_head
    logic [NumSlots-1:0] hit;
    for (genvar s = 0; s < NumSlots; s++) begin : g_slot
      assign hit[s] = slots[s].valid
                   && (slots[s].id == IDWidth'(x))
                   && (slots[s].seq == deq_seq[x])
                   && (slots[s].cnt == '0);
    end
    assign release_en_o[x] = |hit;
  end

  assign rsp_head_seq = deq_seq[rsp_id_i];
  assign retire = rsp_valid_i && rsp_ready_i
               && release_en_o[rsp_id_i];

  for (genvar s = 0; s < NumSlots; s++) begin : g_retire
    assign retire_hit[s] = slots[s].valid
                        && (slots[s].id == rsp_id_i)
                        && (slots[s].seq == rsp_head_seq);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NumSlots; s++) begin
        slots[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NumSlots; s++) begin
        if (accept && (free_idx == SlotIdxWidth'(s))) begin
          slots[s] <= '{valid: 1'b1,
                        id:    req_id_i,
                        seq:   req_seq,
                        cnt:   req_delay_i};
        end else if (retire && retire_hit[s]) begin
          slots[s].valid <= 1'b0;
        end else if (slots[s].valid && (slots[s].cnt != '0)) begin
          slots[s].cnt <= slots[s].cnt - DelayWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int x = 0; x < NumIds; x++) begin
        enq_seq[x] <= '0;
        deq_seq[x] <= '0;
      end
    end else begin
      if (accept) begin
        enq_seq[req_id_i] <= req_seq + SeqWidth'(1);
      end
      if (retire) begin
        deq_seq[rsp_id_i] <= rsp_head_seq + SeqWidth'(1);
      end
    end
  end

  // A handshake on an ID that is not released breaks same-ID ordering.
  retire_legal: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_i && rsp_ready_i) |-> release_en_o[rsp_id_i]
  );

  accept_free: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    accept |-> !slot_valid[free_idx]
  );

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Bench for the release scheduler against a per-request queue model.
// Each outstanding request keeps its own remaining delay; heads are first-of-ID.
module tb_simmem_release_scheduler;
  import simmem_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  req_valid_i = 1'b0;
  logic                  req_ready_o;
  logic [IDWidth-1:0]    req_id_i = '0;
  logic [DelayWidth-1:0] req_delay_i = '0;
  logic [NumIds-1:0]     release_en_o;
  logic                  rsp_valid_i = 1'b0;
  logic                  rsp_ready_i = 1'b0;
  logic [IDWidth-1:0]    rsp_id_i = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int id;
    int rem;
  } req_t;

  req_t mq[$];

  simmem_release_scheduler dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_id_i     (req_id_i),
    .req_delay_i  (req_delay_i),
    .release_en_o (release_en_o),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_i     (rsp_id_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [NumIds-1:0] model_rel();
    logic [NumIds-1:0] r = '0;
    logic [NumIds-1:0] seen = '0;
    foreach (mq[i]) begin
      if (!seen[mq[i].id]) begin
        seen[mq[i].id] = 1'b1;
        if (mq[i].rem == 0) r[mq[i].id] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic model_ready();
    return mq.size() < NumSlots;
  endfunction

  // One clock: drive, take the edge, advance the model, sample at +1.
  task automatic step(input bit v, input int id, input int d,
                      input bit rv, input bit rr, input int rid,
                      output bit acc);
    logic [NumIds-1:0] rel;
    req_valid_i = v;
    req_id_i    = IDWidth'(id);
    req_delay_i = DelayWidth'(d);
    rsp_valid_i = rv;
    rsp_ready_i = rr;
    rsp_id_i    = IDWidth'(rid);
    rel = model_rel();
    acc = v && model_ready();
    @(posedge clk_i);
    #1;
    if (rv && rr && rel[rid]) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].id == rid) begin
          mq.delete(i);
          break;
        end
      end
    end
    foreach (mq[i]) if (mq[i].rem > 0) mq[i].rem--;
    if (acc) mq.push_back('{id, d});
    req_valid_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    mq.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if (release_en_o !== '0) begin
      errors++;
      $display("FAIL reset_rel got %h want 0", release_en_o);
    end
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", req_ready_o);
    end
  endtask

  task automatic test_single();
    bit acc;
    step(1, 3, 5, 0, 0, 0, acc);
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (release_en_o[3] !== (c >= 6)) begin
        errors++;
        $display("FAIL single_c%0d got %b want %b",
                 c, release_en_o[3], c >= 6);
      end
      if (c < 7) step(0, 0, 0, 0, 0, 0, acc);
    end
    step(0, 0, 0, 1, 1, 3, acc);
    checks++;
    if (release_en_o !== '0) begin
      errors++;
      $display("FAIL single_retire got %h want 0", release_en_o);
    end
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b want 1", req_ready_o);
    end
  endtask

  task automatic test_order();
    bit acc;
    step(1, 1, 10, 0, 0, 0, acc);
    step(1, 1, 2, 0, 0, 0, acc);
    for (int c = 2; c <= 11; c++) begin
      checks++;
      if (release_en_o[1] !== (c == 11)) begin
        errors++;
        $display("FAIL order_c%0d got %b want %b",
                 c, release_en_o[1], c == 11);
      end
      if (c < 11) step(0, 0, 0, 0, 0, 0, acc);
    end
    step(0, 0, 0, 1, 1, 1, acc);
    checks++;
    if (release_en_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL order_nogap got %b want 1", release_en_o[1]);
    end
    step(0, 0, 0, 1, 1, 1, acc);
    checks++;
    if (release_en_o !== '0) begin
      errors++;
      $display("FAIL order_done got %h want 0", release_en_o);
    end
  endtask

  task automatic test_zero_delay();
    bit acc;
    step(1, 2, 0, 0, 0, 0, acc);
    checks++;
    if (release_en_o[4:2] !== 3'b001) begin
      errors++;
      $display("FAIL zero_a got %b want 001", release_en_o[4:2]);
    end
    step(1, 4, 0, 0, 0, 0, acc);
    checks++;
    if (release_en_o[4:2] !== 3'b101) begin
      errors++;
      $display("FAIL zero_b got %b want 101", release_en_o[4:2]);
    end
    step(0, 0, 0, 1, 1, 2, acc);
    checks++;
    if (release_en_o[4:2] !== 3'b100) begin
      errors++;
      $display("FAIL zero_c got %b want 100", release_en_o[4:2]);
    end
    step(0, 0, 0, 1, 1, 4, acc);
    checks++;
    if (release_en_o !== '0) begin
      errors++;
      $display("FAIL zero_d got %h want 0", release_en_o);
    end
  endtask

  task automatic test_drain();
    bit acc;
    logic [NumIds-1:0] rel;
    int rid;
    int guard = 0;
    while (mq.size() > 0 && guard < 1000) begin
      rel = model_rel();
      rid = -1;
      for (int x = 0; x < NumIds; x++) begin
        if (rel[x] && rid < 0) rid = x;
      end
      if (rid >= 0) step(0, 0, 0, 1, 1, rid, acc);
      else step(0, 0, 0, 0, 0, 0, acc);
      checks++;
      if (release_en_o !== model_rel()) begin
        errors++;
        $display("FAIL drain_rel got %h want %h",
                 release_en_o, model_rel());
      end
      guard++;
    end
    checks++;
    if (mq.size() != 0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_end left %0d ready %b want 0 and 1",
               mq.size(), req_ready_o);
    end
  endtask

  task automatic test_full();
    bit acc;
    bit done = 0;
    for (int i = 0; i < NumSlots; i++) step(1, 16 + i, 255, 0, 0, 0, acc);
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b want 0", req_ready_o);
    end
    for (int c = 0; c < 400 && !done; c++) begin
      if (model_rel()[16]) begin
        step(1, 40, 3, 1, 1, 16, acc);
        done = 1;
      end else begin
        step(1, 40, 3, 0, 0, 0, acc);
        checks++;
        if (req_ready_o !== 1'b0 || release_en_o !== model_rel()) begin
          errors++;
          $display("FAIL full_wait ready %b rel %h want 0 %h",
                   req_ready_o, release_en_o, model_rel());
        end
      end
    end
    checks++;
    if (!done || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL full_free done %b ready %b want 1 1",
               done, req_ready_o);
    end
    step(1, 40, 3, 0, 0, 0, acc);
    checks++;
    if (req_ready_o !== 1'b0 || !acc) begin
      errors++;
      $display("FAIL full_refill ready %b acc %b want 0 1",
               req_ready_o, acc);
    end
    test_drain();
  endtask

  task automatic test_back_to_back();
    bit acc;
    bit rv;
    int sent = 0;
    int retired = 0;
    for (int c = 0; c < 3000 && retired < 40; c++) begin
      rv = model_rel()[7];
      step(sent < 40, 7, $urandom_range(0, 20), rv, rv, 7, acc);
      if (acc) sent++;
      if (rv) retired++;
      checks++;
      if (release_en_o !== model_rel() || req_ready_o !== model_ready()) begin
        errors++;
        $display("FAIL b2b_c%0d rel %h ready %b want %h %b", c,
                 release_en_o, req_ready_o, model_rel(), model_ready());
      end
    end
    checks++;
    if (retired != 40) begin
      errors++;
      $display("FAIL b2b_count got %0d want 40", retired);
    end
  endtask

  task automatic test_random();
    bit acc;
    bit legal;
    int rid;
    for (int c = 0; c < 400; c++) begin
      rid = $urandom_range(0, 3);
      legal = model_rel()[rid];
      step($urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 12), $urandom_range(0, 1),
           legal ? 1'($urandom_range(0, 1)) : 1'b0, rid, acc);
      checks++;
      if (release_en_o !== model_rel() || req_ready_o !== model_ready()) begin
        errors++;
        $display("FAIL rand_c%0d rel %h ready %b want %h %b", c,
                 release_en_o, req_ready_o, model_rel(), model_ready());
      end
    end
    test_drain();
  endtask

  task automatic test_reset_mid();
    bit acc;
    for (int i = 0; i < 8; i++) step(1, 8 + i, i % 3, 0, 0, 0, acc);
    checks++;
    if (release_en_o !== model_rel()) begin
      errors++;
      $display("FAIL mid_pre got %h want %h", release_en_o, model_rel());
    end
    #2;
    rst_ni = 1'b0;
    #1;
    mq.delete();
    checks++;
    if (release_en_o !== '0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset rel %h ready %b want 0 1",
               release_en_o, req_ready_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0, 0, 0, 0, acc);
      checks++;
      if (release_en_o !== '0) begin
        errors++;
        $display("FAIL mid_idle%0d got %h want 0", c, release_en_o);
      end
    end
    step(1, 9, 2, 0, 0, 0, acc);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (release_en_o !== model_rel()) begin
        errors++;
        $display("FAIL mid_fresh%0d got %h want %h",
                 c, release_en_o, model_rel());
      end
      step(0, 0, 0, 0, 0, 0, acc);
    end
    test_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_zero_delay();
    test_full();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
